spi_shift_register: RTL and testbench

- Data shifter for the APB SPI master; sits directly downstream of the baud-rate generator.
- Consumes the generator's sclk edge strobes (flag_low, flag_high) and the cpol/cpha/lsbfe configuration.
- Serialises one transmit byte onto mosi while deserialising miso into a receive byte.
- Signals completion to the SPI control FSM and the data register.

---
 rtl/spi_shift_register.sv | 70 +++++++
 tb/tb_spi_shift_register.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/spi_shift_register.sv
// spi_shift_register: SPI frame shifter driven by baud-generator sclk edge strobes, cpol/cpha/lsbfe aware.
module spi_shift_register #(
  parameter int DATA_W = 8
) (
  input  logic              PClk,
  input  logic              PRESET,
  input  logic              ss,
  input  logic              send_data,
  input  logic [DATA_W-1:0] data_mosi,
  input  logic              lsbfe,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              flag_high,
  input  logic              flag_low,
  input  logic              miso,
  output logic              mosi,
  output logic [DATA_W-1:0] data_miso,
  output logic              receive_data,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] tx_reg, rx_reg, rx_d;
  logic [CW-1:0] tx_cnt, rx_cnt, tx_cnt_d;
  logic [IW-1:0] rx_pos, tx_pos;
  logic leading, trailing, sample, shift, load, run, rx_go, tx_go, last;
  // A cpha=1 frame already presents bit 0, so its first leading edge (no samples yet) must not advance.
  always_comb begin
    leading = cpol ? flag_low : flag_high;
    trailing = cpol ? flag_high : flag_low;
    sample = cpha ? trailing : leading;
    shift = (cpha ? leading : trailing) & ~sample;
    load = state == IDLE && send_data && !ss;
    run = state == ACTIVE && !ss;
    rx_go = run && sample && rx_cnt < CW'(DATA_W);
    last = rx_go && rx_cnt == CW'(DATA_W - 1);
    tx_go = run && shift && tx_cnt < CW'(DATA_W - 1) && (!cpha || rx_cnt != '0);
    tx_cnt_d = tx_go ? tx_cnt + CW'(1) : tx_cnt;
    rx_pos = lsbfe ? IW'(rx_cnt) : IW'(CW'(DATA_W - 1) - rx_cnt);
    tx_pos = lsbfe ? IW'(tx_cnt_d) : IW'(CW'(DATA_W - 1) - tx_cnt_d);
    rx_d = rx_reg;
    if (rx_go) rx_d[rx_pos] = miso;
    state_d = load ? ACTIVE : state == ACTIVE ? (ss ? IDLE : last ? DONE : ACTIVE) : IDLE;
    busy = state == ACTIVE;
    receive_data = state == DONE;
  end
  always_ff @(posedge PClk or posedge PRESET)
    if (PRESET) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge PClk or posedge PRESET) begin
    if (PRESET) begin
      tx_reg <= '0;
      rx_reg <= '0;
      data_miso <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      mosi <= 1'b0;
    end else begin
      tx_reg <= load ? data_mosi : tx_reg;
      rx_reg <= load ? '0 : rx_d;
      tx_cnt <= load ? '0 : tx_cnt_d;
      rx_cnt <= load ? '0 : rx_go ? rx_cnt + CW'(1) : rx_cnt;
      mosi <= load ? (lsbfe ? data_mosi[0] : data_mosi[DATA_W-1]) :
              (state == ACTIVE && ss) ? 1'b0 : run ? tx_reg[tx_pos] : mosi;
      if (last) data_miso <= rx_d;
    end
  end
endmodule

// File: tb/tb_spi_shift_register.sv
// tb_spi_shift_register: directed SPI frames in all modes against an edge-level bench model.
module tb_spi_shift_register;
  logic PClk = 0, PRESET, ss, send_data, lsbfe, cpol, cpha, flag_high, flag_low, miso, miso_drv, lpbk;
  logic [7:0] data_mosi, data_miso, cap;
  logic mosi, receive_data, busy;
  logic exp_busy, exp_rd, exp_mosi, chk_en;
  logic [7:0] exp_dmiso;
  int checks = 0, errors = 0;

  spi_shift_register #(.DATA_W(8)) dut (
    .PClk(PClk), .PRESET(PRESET), .ss(ss), .send_data(send_data), .data_mosi(data_mosi),
    .lsbfe(lsbfe), .cpol(cpol), .cpha(cpha), .flag_high(flag_high), .flag_low(flag_low),
    .miso(miso), .mosi(mosi), .data_miso(data_miso), .receive_data(receive_data), .busy(busy)
  );

  always #5 PClk = ~PClk;
  assign miso = lpbk ? mosi : miso_drv;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PClk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] d, input int i, input logic lsb);
    return lsb ? d[i] : d[7-i];
  endfunction

  always @(negedge PClk)
    if (chk_en) begin
      check("busy", {7'd0, busy}, {7'd0, exp_busy});
      check("receive_data", {7'd0, receive_data}, {7'd0, exp_rd});
      check("mosi", {7'd0, mosi}, {7'd0, exp_mosi});
      check("data_miso", data_miso, exp_dmiso);
    end

  // After a shift edge the slave must see frame bit number <samples taken>; a final sample completes the byte.
  task automatic frame(input logic pol, input logic pha, input logic lsb, input logic [7:0] d,
                       input logic [7:0] mb, input logic lp, input int abort_at, input int resend_at,
                       output logic [7:0] lead_cap);
    int s;
    logic lead, samp;
    s = 0;
    lead_cap = 8'h00;
    cpol = pol; cpha = pha; lsbfe = lsb; lpbk = lp;
    ss = 0; data_mosi = d; send_data = 1;
    tick;
    send_data = 0; data_mosi = 8'h00;
    exp_busy = 1; exp_mosi = fbit(d, 0, lsb);
    repeat (2) tick;
    for (int e = 0; e < 16; e++) begin
      lead = (e % 2) == 0;
      samp = pha ? !lead : lead;
      if (s == abort_at && !samp) begin
        ss = 1;
        tick;
        exp_busy = 0; exp_mosi = 0;
        repeat (3) tick;
        return;
      end
      if (e == resend_at) begin send_data = 1; data_mosi = 8'hFF; end
      if (samp && !lp) miso_drv = fbit(mb, s, lsb);
      if (lead) lead_cap = {lead_cap[6:0], mosi};
      if (lead == pol) flag_low = 1; else flag_high = 1;
      tick;
      flag_high = 0; flag_low = 0; send_data = 0; data_mosi = 8'h00;
      if (samp) begin
        s++;
        if (s == 8) begin
          exp_busy = 0; exp_rd = 1; exp_dmiso = lp ? d : mb;
          tick;
          exp_rd = 0;
          repeat (2) tick;
          return;
        end
      end else exp_mosi = fbit(d, s, lsb);
      repeat (2) tick;
    end
  endtask

  initial begin
    PRESET = 1; ss = 1; send_data = 0; data_mosi = 0; lsbfe = 0; cpol = 0; cpha = 0;
    flag_high = 0; flag_low = 0; miso_drv = 0; lpbk = 0;
    exp_busy = 0; exp_rd = 0; exp_mosi = 0; exp_dmiso = 0; chk_en = 0;
    repeat (2) tick;
    PRESET = 0;
    chk_en = 1;
    tick;
    check("reset_outputs", {data_miso[4:0], mosi, busy, receive_data}, 8'h00);
    frame(0, 0, 0, 8'hA5, 8'h3C, 0, -1, -1, cap);
    check("mode0_mosi_leading", cap, 8'hA5);
    check("mode0_rx", data_miso, 8'h3C);
    check("mode0_mosi_hold", {7'd0, mosi}, 8'h01);
    frame(1, 1, 1, 8'h01, 8'hFF, 0, -1, -1, cap);
    check("mode3_rx", data_miso, 8'hFF);
    frame(0, 1, 0, 8'hC3, 8'h00, 1, -1, -1, cap);
    check("mode1_loop", data_miso, 8'hC3);
    frame(1, 0, 0, 8'hC3, 8'h00, 1, -1, -1, cap);
    check("mode2_loop", data_miso, 8'hC3);
    frame(0, 0, 0, 8'h55, 8'hAA, 0, 4, -1, cap);
    check("abort_keep", data_miso, 8'hC3);
    check("abort_idle", {6'd0, busy, mosi}, 8'h00);
    frame(0, 0, 0, 8'h96, 8'h5A, 0, -1, 5, cap);
    check("resend_mosi", cap, 8'h96);
    check("resend_rx", data_miso, 8'h5A);
    frame(1, 0, 1, 8'h2D, 8'h81, 0, -1, -1, cap);
    check("mode2_lsb_rx", data_miso, 8'h81);
    cpol = 0; cpha = 0; lsbfe = 0; lpbk = 0;
    ss = 0; data_mosi = 8'hF0; send_data = 1;
    tick;
    send_data = 0; exp_busy = 1; exp_mosi = 1;
    tick;
    flag_high = 1;
    tick;
    flag_high = 0;
    #2 PRESET = 1;
    chk_en = 0;
    #1;
    check("areset_dmiso", data_miso, 8'h00);
    check("areset_mosi_busy_rd", {5'd0, mosi, busy, receive_data}, 8'h00);
    tick;
    PRESET = 0;
    exp_busy = 0; exp_rd = 0; exp_mosi = 0; exp_dmiso = 0;
    chk_en = 1;
    tick;
    frame(0, 0, 0, 8'h3A, 8'hE1, 0, -1, -1, cap);
    check("post_reset_mosi", cap, 8'h3A);
    check("post_reset_rx", data_miso, 8'hE1);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
